// File: rtl/spi_ram_burst.sv
// Parametrised single-port RAM behind the SPI slave command port.
// Decodes {cmd, payload} words into address loads, writes and pipelined reads.
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              err
);

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_t;

  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(MEM_DEPTH - 1);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0] addr_wr;
  logic [ADDR_W-1:0] addr_rd;

  cmd_t              cmd;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] addr_in;
  logic              in_range;
  logic              wr_go;
  logic              rd_go;

  logic [RD_LAT-1:0] pipe_vld;
  logic [DATA_W-1:0] pipe_dat [RD_LAT];

  assign cmd      = cmd_t'(din[DATA_W+1:DATA_W]);
  assign payload  = din[DATA_W-1:0];
  assign addr_in  = payload[ADDR_W-1:0];
  assign in_range = {1'b0, addr_in} < DEPTH;
  assign wr_go    = rst_n && rx_valid && (cmd == WR_DATA);
  assign rd_go    = rx_valid && (cmd == RD_DATA);

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if (AUTO_INC == 0) return a;
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_wr <= '0;
      addr_rd <= '0;
      err     <= 1'b0;
    end else if (rx_valid) begin
      case (cmd)
        WR_ADDR: if (in_range) addr_wr <= addr_in; else err <= 1'b1;
        WR_DATA: addr_wr <= next_addr(addr_wr);
        RD_ADDR: if (in_range) addr_rd <= addr_in; else err <= 1'b1;
        RD_DATA: addr_rd <= next_addr(addr_rd);
        default: ;
      endcase
    end
  end

  // RAM contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge clk) begin
    if (wr_go) mem[addr_wr] <= payload;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      tx_valid <= 1'b0;
      dout     <= '0;
    end else begin
      pipe_vld[0] <= rd_go;
      if (rd_go) pipe_dat[0] <= mem[addr_rd];
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
      tx_valid <= pipe_vld[RD_LAT-1];
      if (pipe_vld[RD_LAT-1]) dout <= pipe_dat[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst: two instances (256-deep auto-inc RD_LAT=1, 200-deep static RD_LAT=2)
// share the stimulus and are checked every cycle against an abstract command model.
module tb_spi_ram_burst;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [9:0] din;

  logic [7:0] dout_a, dout_b;
  logic       tx_a, tx_b, err_a, err_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din),
    .dout(dout_a), .tx_valid(tx_a), .err(err_a));

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(0), .RD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din),
    .dout(dout_b), .tx_valid(tx_b), .err(err_b));

  // Model state, index 0 = dut_a, 1 = dut_b.
  logic [7:0] mem_m  [2][256];
  int         awr_m  [2];
  int         ard_m  [2];
  logic       err_m  [2];
  logic [7:0] last_m [2];
  int         due0[$], due1[$];
  logic [7:0] dat0[$], dat1[$];
  logic [7:0] log_a[$], log_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int depth_of(input int k);
    return (k == 0) ? 256 : 200;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      awr_m[k] = 0; ard_m[k] = 0; err_m[k] = 1'b0; last_m[k] = 8'h00;
    end
    due0.delete(); due1.delete(); dat0.delete(); dat1.delete();
  endtask

  task automatic model_cmd(input int k, input logic [9:0] w);
    int d, inc, lat, p;
    d   = depth_of(k);
    inc = (k == 0) ? 1 : 0;
    lat = (k == 0) ? 1 : 2;
    p   = int'(w[7:0]);
    case (w[9:8])
      2'b00: if (p < d) awr_m[k] = p; else err_m[k] = 1'b1;
      2'b01: begin
        mem_m[k][awr_m[k]] = w[7:0];
        if (inc != 0) awr_m[k] = (awr_m[k] + 1) % d;
      end
      2'b10: if (p < d) ard_m[k] = p; else err_m[k] = 1'b1;
      default: begin
        if (k == 0) begin due0.push_back(cyc + lat); dat0.push_back(mem_m[k][ard_m[k]]); end
        else        begin due1.push_back(cyc + lat); dat1.push_back(mem_m[k][ard_m[k]]); end
        if (inc != 0) ard_m[k] = (ard_m[k] + 1) % d;
      end
    endcase
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) mem_m[k][a] = 8'hxx;
    model_reset();
  end

  // Model update on the edge, comparison 1 time unit later.
  always @(posedge clk) begin
    logic exp_v;
    logic [7:0] d;
    cyc++;
    if (!rst_n) model_reset();
    else if (rx_valid) begin
      model_cmd(0, din);
      model_cmd(1, din);
    end
    #1;
    exp_v = (due0.size() > 0) && (due0[0] == cyc);
    chk("tx_valid_a", {31'd0, tx_a}, {31'd0, exp_v});
    if (exp_v) begin d = dat0.pop_front(); void'(due0.pop_front()); last_m[0] = d; end
    if (!$isunknown(last_m[0])) chk("dout_a", {24'd0, dout_a}, {24'd0, last_m[0]});
    chk("err_a", {31'd0, err_a}, {31'd0, err_m[0]});
    exp_v = (due1.size() > 0) && (due1[0] == cyc);
    chk("tx_valid_b", {31'd0, tx_b}, {31'd0, exp_v});
    if (exp_v) begin d = dat1.pop_front(); void'(due1.pop_front()); last_m[1] = d; end
    if (!$isunknown(last_m[1])) chk("dout_b", {24'd0, dout_b}, {24'd0, last_m[1]});
    chk("err_b", {31'd0, err_b}, {31'd0, err_m[1]});
    if (tx_a) log_a.push_back(dout_a);
    if (tx_b) log_b.push_back(dout_b);
  end

  function automatic logic [31:0] pack(input logic [7:0] q[$]);
    logic [31:0] v = 32'd0;
    foreach (q[i]) v = (v << 8) | {24'd0, q[i]};
    return v;
  endfunction

  task automatic send(input logic [1:0] c, input logic [7:0] p);
    rx_valid = 1'b1;
    din      = {c, p};
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    log_a.delete();
    log_b.delete();
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_dout_a", {24'd0, dout_a}, 32'h0);
    chk("reset_tx_b", {31'd0, tx_b}, 32'h0);
    chk("reset_err_b", {31'd0, err_b}, 32'h0);

    // single write then read
    clear_logs();
    send(2'b00, 8'h10); send(2'b01, 8'hA5); send(2'b10, 8'h10); send(2'b11, 8'h00);
    idle(4);
    chk("t2_a_pulses", log_a.size(), 1);
    chk("t2_a_data", pack(log_a), 32'hA5);
    chk("t2_b_data", pack(log_b), 32'hA5);

    // burst with wrap; dut_b rejects 0xFE and reads its static pointer
    clear_logs();
    send(2'b00, 8'hFE); send(2'b01, 8'h11); send(2'b01, 8'h22); send(2'b01, 8'h33);
    send(2'b10, 8'hFE); send(2'b11, 8'h00); send(2'b11, 8'h00); send(2'b11, 8'h00);
    idle(5);
    chk("t3_a_burst", pack(log_a), 32'h00112233);
    chk("t3_b_static", pack(log_b), 32'h00333333);
    chk("t3_err_a", {31'd0, err_a}, 32'h0);
    chk("t3_err_b", {31'd0, err_b}, 32'h1);

    // reset lands while a read is in flight
    clear_logs();
    send(2'b10, 8'h10);
    rx_valid = 1'b1; din = {2'b11, 8'h00};
    @(negedge clk);
    rx_valid = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    chk("t1_no_pulse", log_a.size() + log_b.size(), 0);
    chk("t1_dout_b", {24'd0, dout_b}, 32'h0);
    chk("t1_err_b", {31'd0, err_b}, 32'h0);

    // out-of-range load keeps the old pointer
    clear_logs();
    send(2'b00, 8'h05); send(2'b00, 8'hC8); send(2'b01, 8'h5A);
    send(2'b10, 8'h05); send(2'b10, 8'hC8); send(2'b11, 8'h00);
    idle(4);
    chk("t4_err_a", {31'd0, err_a}, 32'h0);
    chk("t4_err_b", {31'd0, err_b}, 32'h1);
    chk("t4_a_data", pack(log_a), 32'h5A);
    chk("t4_b_data", pack(log_b), 32'h5A);

    // read cmd without rx_valid, then read-after-write on adjacent cycles
    clear_logs();
    rx_valid = 1'b0; din = {2'b11, 8'h00};
    @(negedge clk);
    idle(3);
    chk("t5_gated", log_a.size() + log_b.size(), 0);
    send(2'b00, 8'h20); send(2'b10, 8'h20);
    send(2'b01, 8'h3C); send(2'b11, 8'h00);
    send(2'b01, 8'h4D); send(2'b11, 8'h00);
    idle(4);
    chk("t5_a_raw", pack(log_a), 32'h3C4D);
    chk("t5_b_raw", pack(log_b), 32'h3C4D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
